// File: rtl/interp_sequencer_10x_pkg.sv
// Shared constants and types for the 10x interpolation frame sequencer.
package interp_sequencer_10x_pkg;

    // Width of one base-rate sample.
    localparam int unsigned SAMPLE_W   = 8;

    // A frame is ten ticks long: phase 0 starts it, 8 is the MSB stage, 9 ends it.
    localparam int unsigned NUM_PHASES = 10;
    localparam int unsigned MSB_PHASE  = 8;
    localparam int unsigned END_PHASE  = 9;

    // Enough bits to hold phases 0..NUM_PHASES-1.
    localparam int unsigned PH_W       = 4;

    // Prescaler counter width; PRESCALE tops out at 255.
    localparam int unsigned PRE_W      = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } seq_state_e;

    // Phase successor with wrap from the last phase back to 0.
    function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] ph);
        logic [PH_W-1:0] nxt;
        if (ph == PH_W'(NUM_PHASES - 1)) begin
            nxt = '0;
        end else begin
            nxt = ph + PH_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tick_gen_10x.sv
// Prescaler and frame-phase counter pair. Produces one tick every PRESCALE clks while
// enabled, and the phase (0..9) that the current/next tick belongs to.
module tick_gen_10x
    import interp_sequencer_10x_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic            clk,
    input  logic            reset,   // active-low, deassertion already synchronised
    input  logic            enable,  // sequencer is framing this clk
    input  logic            clear,   // sequencer returns to idle after this clk
    output logic            tick,
    output logic [PH_W-1:0] ph
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;

    // A tick is the first clk of every prescale period; never outside framing.
    assign tick = enable && (pre_cnt_q == '0);
    assign ph   = ph_q;

    // Next-state: wrap the prescaler, step the phase on each tick, zero both on clear.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        ph_d      = ph_q;
        if (clear) begin
            pre_cnt_d = '0;
            ph_d      = '0;
        end else if (enable) begin
            if (pre_cnt_q == PRE_W'(PRESCALE - 1)) begin
                pre_cnt_d = '0;
            end else begin
                pre_cnt_d = pre_cnt_q + PRE_W'(1);
            end
            if (tick) begin
                ph_d = next_phase(ph_q);
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt_q <= '0;
            ph_q      <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            ph_q      <= ph_d;
        end
    end

endmodule

// File: rtl/interp_sequencer_10x.sv
// 10x interpolation frame sequencer: frames of ten ticks, a one-entry input holding
// register, and a TAPS-deep sample window shifted once per frame.
module interp_sequencer_10x
    import interp_sequencer_10x_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned TAPS     = 11
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SAMPLE_W-1:0]        in_data,
    output logic                       clk_en,
    output logic                       clk_en_10x,
    output logic                       msb_stage,
    output logic                       end_stage,
    output logic [SAMPLE_W*TAPS-1:0]   win_data,
    output logic                       y_valid,
    output logic                       underrun,
    input  logic                       clr_underrun
);

    localparam int unsigned WIN_W = SAMPLE_W * TAPS;

    logic [1:0]          rst_sync_q;
    logic                rst_n;

    seq_state_e          state_q, state_d;
    logic                tick;
    logic [PH_W-1:0]     ph;

    logic                hold_full_q, hold_full_d;
    logic [SAMPLE_W-1:0] hold_data_q, hold_data_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic                underrun_q, underrun_d;
    logic                y_valid_q;

    logic                accept;
    logic                consume;
    logic [SAMPLE_W-1:0] insert;

    // Reset asserts asynchronously but releases only after two clean clk edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    tick_gen_10x #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (rst_n),
        .enable (state_q != StIdle),
        .clear  (state_d == StIdle),
        .tick   (tick),
        .ph     (ph)
    );

    // Strobes decode registered counter state only, so they cannot glitch.
    assign clk_en     = tick && (ph == '0);
    assign clk_en_10x = tick;
    assign msb_stage  = tick && (ph == PH_W'(MSB_PHASE));
    assign end_stage  = tick && (ph == PH_W'(END_PHASE));

    // Framing FSM. run=0 is honoured immediately only between the end tick and the
    // next frame start; inside a frame it parks in DRAIN so the frame completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!run) begin
                    // Past the end tick (ph already wrapped to 0, not yet a tick).
                    if (end_stage || ((ph == '0) && !tick)) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (run) begin
                    state_d = StRun;
                end else if (end_stage) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // The holding register frees up on the clk that a running frame consumes it.
    assign consume  = clk_en && (state_q == StRun);
    assign in_ready = !hold_full_q || (clk_en && (state_q != StDrain));
    assign accept   = in_valid && in_ready;
    assign insert   = hold_full_q ? hold_data_q : '0;

    // Next-state for holding register, window and sticky underrun flag.
    always_comb begin
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        win_d       = win_q;
        underrun_d  = underrun_q;
        if (consume) begin
            win_d       = {win_q[WIN_W-SAMPLE_W-1:0], insert};
            hold_full_d = 1'b0;
        end
        // Accepting on the consume clk refills the register with the new sample.
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = in_data;
        end
        if (clr_underrun) begin
            underrun_d = 1'b0;
        end else if (consume && !hold_full_q) begin
            underrun_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            win_q       <= '0;
            underrun_q  <= 1'b0;
            y_valid_q   <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            win_q       <= win_d;
            underrun_q  <= underrun_d;
            y_valid_q   <= end_stage;
        end
    end

    assign win_data = win_q;
    assign underrun = underrun_q;
    assign y_valid  = y_valid_q;

endmodule

// File: tb/tb_interp_sequencer_10x.sv
// Scoreboard bench for interp_sequencer_10x with a frame-level reference model.
module tb_interp_sequencer_10x;

    localparam int unsigned P  = 4;
    localparam int unsigned T  = 11;
    localparam int unsigned F  = 10 * P;
    localparam int unsigned WW = 8 * T;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          clk_en;
    logic          clk_en_10x;
    logic          msb_stage;
    logic          end_stage;
    logic [WW-1:0] win_data;
    logic          y_valid;
    logic          underrun;
    logic          clr_underrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    interp_sequencer_10x #(
        .PRESCALE (P),
        .TAPS     (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .clk_en       (clk_en),
        .clk_en_10x   (clk_en_10x),
        .msb_stage    (msb_stage),
        .end_stage    (end_stage),
        .win_data     (win_data),
        .y_valid      (y_valid),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: framing by cycle arithmetic, samples as plain queues.
    bit            m_active;
    int unsigned   m_t;
    bit            m_yv_pend;
    bit            m_ur;
    logic [7:0]    m_hold[$];
    logic [7:0]    m_hist[$];
    logic [WW-1:0] exp_q[$];

    function automatic logic [WW-1:0] hist_window();
        logic [WW-1:0] w;
        w = '0;
        foreach (m_hist[i]) w = {w[WW-9:0], m_hist[i]};
        return w;
    endfunction

    always @(negedge clk) begin : model
        int unsigned cyc;
        bit          e_tick, e_ce, e_msb, e_end, e_rdy, set_ur;
        logic [7:0]  v;
        if (!reset) begin
            m_active  = 1'b0;
            m_t       = 0;
            m_yv_pend = 1'b0;
            m_ur      = 1'b0;
            m_hold.delete();
            exp_q.delete();
            m_hist.delete();
            for (int i = 0; i < T; i++) m_hist.push_back(8'h00);
        end
        cyc    = m_t % F;
        e_tick = m_active && (cyc % P == 0);
        e_ce   = m_active && (cyc == 0);
        e_msb  = m_active && (cyc == 8 * P);
        e_end  = m_active && (cyc == 9 * P);
        e_rdy  = (m_hold.size() == 0) || e_ce;
        chk("strobes", {clk_en, clk_en_10x, msb_stage, end_stage, y_valid, in_ready, underrun},
            {e_ce, e_tick, e_msb, e_end, m_yv_pend, e_rdy, m_ur});
        if (reset) begin
            set_ur = 1'b0;
            if (e_ce) begin
                if (m_hold.size() > 0) begin
                    v = m_hold.pop_front();
                end else begin
                    v      = 8'h00;
                    set_ur = 1'b1;
                end
                m_hist.push_back(v);
                void'(m_hist.pop_front());
                exp_q.push_back(hist_window());
            end
            if (in_valid && e_rdy) m_hold.push_back(in_data);
            if (clr_underrun) m_ur = 1'b0;
            else if (set_ur) m_ur = 1'b1;
            m_yv_pend = e_end;
            // run is only honoured from the end tick up to the next frame start.
            if (m_active) begin
                if (!run && (cyc >= 9 * P)) begin
                    m_active = 1'b0;
                    m_t      = 0;
                end else begin
                    m_t++;
                end
            end else if (run) begin
                m_active = 1'b1;
                m_t      = 0;
            end
        end
    end

    // Scoreboard monitor: every y_valid retires one expected window.
    always @(negedge clk) begin : scoreboard
        logic [WW-1:0] e;
        if (reset && y_valid) begin
            chk("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("window", win_data, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 4 * F; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        step();
        in_valid = 1'b0;
        chk("send_accept", got, 1);
    endtask

    task automatic wait_ce();
        bit got;
        got = 1'b0;
        for (int k = 0; k < 4 * F; k++) begin
            @(negedge clk);
            if (clk_en) begin
                got = 1'b1;
                break;
            end
        end
        step();
        chk("ce_seen", got, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int rate;
        reset        = 1'b0;
        run          = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        clr_underrun = 1'b0;
        repeat (3) step();
        chk("rst_win", win_data, 0);
        chk("rst_outs", {clk_en, clk_en_10x, msb_stage, end_stage, y_valid, underrun}, 0);
        reset = 1'b1;
        repeat (4) step();

        // Samples offered ahead of each frame; 0x22 lands on the consume clk.
        send(8'h11);
        run = 1'b1;
        send(8'h22);
        send(8'h33);
        wait_ce();
        chk("win_112233", win_data[23:0], 24'h112233);

        // Frame start with nothing held.
        wait_ce();
        chk("underrun_set", underrun, 1);
        chk("win_zero_ins", win_data[31:0], 32'h11223300);
        repeat (5) step();
        chk("underrun_sticky", underrun, 1);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        chk("underrun_clr", underrun, 0);

        run = 1'b0;
        repeat (2 * F) step();

        // Stop request mid-frame at clk 50.
        run = 1'b1;
        step();
        repeat (50) step();
        run = 1'b0;
        repeat (60) step();

        // Asynchronous reset at clk 20, on a 10x tick.
        run = 1'b1;
        step();
        repeat (20) step();
        #2 reset = 1'b0;
        #1;
        chk("async_rst_outs", {clk_en, clk_en_10x, msb_stage, end_stage, y_valid, underrun}, 0);
        chk("async_rst_win", win_data, 0);
        run = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (4) step();
        run = 1'b1;
        step();
        chk("restart_ce", clk_en, 1);

        // Randomised traffic, run toggling and clears.
        for (int i = 0; i < 1600; i++) begin
            rate         = (i < 800) ? 40 : 4;
            in_valid     = ($urandom_range(0, 99) < rate);
            in_data      = 8'($urandom);
            clr_underrun = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 39) == 0) run = ~run;
            step();
        end
        in_valid     = 1'b0;
        clr_underrun = 1'b0;
        run          = 1'b0;
        repeat (3 * F) step();
        chk("sb_drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interp_sequencer_10x.md
INTERP_SEQUENCER_10X -- requirements
Module: interp_sequencer_10x

Interface
REQ-001 Parameter PRESCALE, default 4: clk cycles per 10x tick, legal range 2..255.
REQ-002 Parameter TAPS, default 11: input sample window depth, legal range 2..32.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 requests continuous framing, 0 requests stop at the next frame boundary.
REQ-006 in_valid / in_ready / in_data  input / output / input  1/1/8  base-rate sample stream with valid/ready handshake.
REQ-007 clk_en  output  1  one-clk frame strobe, phase-aligned with clk_en_10x.
REQ-008 clk_en_10x  output  1  one-clk tick strobe, once every PRESCALE clks while framing.
REQ-009 msb_stage  output  1  high only on the tick of phase 8.
REQ-010 end_stage  output  1  high only on the tick of phase 9.
REQ-011 win_data  output  8*TAPS  sample window; bits [7:0] newest, bits [8*TAPS-1:8*TAPS-8] oldest.
REQ-012 y_valid  output  1  one-clk pulse, the clk after end_stage; marks datapath outputs updated.
REQ-013 underrun  output  1  sticky flag: a frame started with no sample held.
REQ-014 clr_underrun  input  1  synchronous clear of underrun.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-016 IDLE SHALL hold pre_cnt=0 and ph=0, with all strobes low.
REQ-017 IDLE->RUN SHALL occur on the first clk with run=1.
REQ-018 The first RUN cycle SHALL be a tick with ph=0.
REQ-019 In RUN and DRAIN, pre_cnt SHALL count 0..PRESCALE-1 and wrap; a tick occurs when pre_cnt=0.
REQ-020 ph SHALL count 0..9, advance on each tick and wrap 9->0.
REQ-021 clk_en SHALL equal (tick AND ph=0); clk_en_10x SHALL be high on that same clk.
REQ-022 msb_stage SHALL equal (tick AND ph=8); end_stage SHALL equal (tick AND ph=9).
REQ-023 Strobes SHALL be combinational from registered state, glitch-free, and never high in IDLE.
REQ-024 Frame period SHALL be exactly 10*PRESCALE clks; msb_stage SHALL occur 8*PRESCALE clks and end_stage 9*PRESCALE clks after clk_en.
REQ-025 RUN->DRAIN SHALL occur when run=0.
REQ-026 DRAIN->RUN SHALL occur if run returns to 1 before the ph=9 tick; framing stays continuous.
REQ-027 DRAIN->IDLE SHALL occur on the clk after the ph=9 tick, so a started frame always completes.
REQ-028 A one-entry holding register SHALL buffer input; in_ready = (!hold_full) OR (clk_en AND state!=DRAIN).
REQ-029 Simultaneous accept and consume SHALL keep hold_full=1 with the new data.
REQ-030 On a clk_en in RUN, win_data SHALL shift by 8 bits, inserting the held sample as newest and discarding the oldest.
REQ-031 On that clk_en, if no sample is held, the block SHALL insert 8'h00 and set underrun.
REQ-032 clr_underrun SHALL win over a simultaneous set.
REQ-033 y_valid SHALL be end_stage delayed by one register.

Reset
REQ-034 Reset asserted SHALL immediately force: state=IDLE, pre_cnt=0, ph=0, hold_full=0, win_data=0, underrun=0, y_valid=0, all strobes 0.
REQ-035 Reset mid-frame SHALL abandon the frame; no end_stage or y_valid follows.
REQ-036 Reset deassertion SHALL be internally synchronised (two-flop) before releasing the state registers.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding (2 bits), the phase constants MSB_PHASE=8, END_PHASE=9 and NUM_PHASES=10, and SAMPLE_W=8.
REQ-038 The prescaler/phase counter pair SHALL be one sub-module, tick_gen_10x (outputs tick and ph); the FSM, handshake and window stay in the top level.

Verification (PRESCALE=4, TAPS=11)
REQ-039 Reset release, run=1 at clk 0: clk_en at clks 0, 40, 80; msb_stage at 32; end_stage at 36; y_valid at 37.
REQ-040 Samples 0x11, 0x22, 0x33 offered ahead of each frame: after the third clk_en, win_data[23:0]=0x112233 and in_ready never drops while the holding register is empty.
REQ-041 No input during a frame start: 0x00 inserted, underrun=1 and held; clr_underrun pulse -> 0 next clk.
REQ-042 run=0 at clk 50: ticks continue, end_stage at 76, IDLE from 77, no further strobes.
REQ-043 Reset asserted at clk 20: all outputs 0 in the same clk; no end_stage ever; restart with run=1 gives clk_en with correct alignment.
REQ-044 in_valid held high with accept and consume on the same clk at clk 40: hold_full stays 1 with the new data and no sample is lost or duplicated.
